// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
//   Issuing side of the video-processor instruction interface. Host commands
//   (opcode, register/address, data) are packed into {dataA, dataB} when they
//   are accepted, buffered in a small FIFO, and issued one per clk_en pulse
//   while the decoder is idle (new_instruction == 0).
//
// Parameters
//   FIFO_DEPTH : command buffer entries (power of two, 2..16)
//   ISSUE_GAP  : idle cycles forced after each issue pulse (0..15)
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   cmd_valid/ready   : host command handshake (ready is combinational)
//   cmd_opcode        : 0 sprite pos, 1 sprite mem write, 2 sprite offset,
//                       3 frame sync, 4..15 illegal (accepted then dropped)
//   cmd_register      : sprite register [4:0] or sprite memory address [16:0]
//   cmd_data          : position / colour / offset value
//   new_instruction   : decoder busy; issue is held while 1
//   dataA, dataB      : issued instruction words (held between issues)
//   clk_en            : one-cycle pulse marking a new instruction
//   fifo_level        : buffered entries, 0..FIFO_DEPTH
//   err_illegal       : one-cycle pulse per dropped illegal opcode
//   err_count         : saturating count of dropped illegal opcodes
// ---------------------------------------------------------------------------
module instruction_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ISSUE_GAP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [16:0] cmd_register,
  input  logic [31:0] cmd_data,
  input  logic        new_instruction,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic        clk_en,
  output logic [4:0]  fifo_level,
  output logic        err_illegal,
  output logic [7:0]  err_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Pack a legal command into {dataA, dataB}; illegal opcodes never reach storage.
  function automatic logic [63:0] encode_cmd(input logic [3:0]  op,
                                             input logic [16:0] regf,
                                             input logic [31:0] data);
    logic [63:0] word;
    case (op)
      4'd0, 4'd2: word = {23'd0, regf[4:0], op, data};
      4'd1:       word = {11'd0, regf, 4'b0001, data};
      4'd3:       word = {28'd0, 4'b0011, 32'd0};
      default:    word = 64'd0;
    endcase
    return word;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [31:0]   dataa_q, dataa_d;
  logic [31:0]   datab_q, datab_d;
  logic          clk_en_q, clk_en_d;
  logic          err_illegal_q, err_illegal_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [63:0]   mem_q [FIFO_DEPTH];

  logic          accept_s;
  logic          write_s;
  logic          illegal_s;
  logic          pop_s;
  logic [63:0]   head_s;

  // No bypass: a full FIFO refuses new commands even if a pop is under way.
  assign cmd_ready = !reset && (level_q != 5'(FIFO_DEPTH));
  assign accept_s  = cmd_valid && cmd_ready;
  assign write_s   = accept_s && (cmd_opcode < 4'd4);
  assign illegal_s = accept_s && (cmd_opcode >= 4'd4);
  assign head_s    = mem_q[rd_ptr_q];

  // Issue FSM: pop in IDLE, pulse clk_en during ISSUE, then hold off in GAP.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    dataa_d  = dataa_q;
    datab_d  = datab_q;
    clk_en_d = 1'b0;
    pop_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level_q != 5'd0) && !new_instruction) begin
          pop_s    = 1'b1;
          dataa_d  = head_s[63:32];
          datab_d  = head_s[31:0];
          clk_en_d = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (ISSUE_GAP > 0) begin
          state_d = S_GAP;
          gap_d   = 4'(ISSUE_GAP - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d   = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_comb begin
    if (write_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({write_s, pop_s})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  // Illegal-opcode pulse and saturating counter.
  always_comb begin
    err_illegal_d = illegal_s;
    if (illegal_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      gap_q         <= 4'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= 5'd0;
      dataa_q       <= 32'd0;
      datab_q       <= 32'd0;
      clk_en_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      dataa_q       <= dataa_d;
      datab_q       <= datab_d;
      clk_en_q      <= clk_en_d;
      err_illegal_q <= err_illegal_d;
      err_count_q   <= err_count_d;
    end
  end

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_q[wr_ptr_q] <= encode_cmd(cmd_opcode, cmd_register, cmd_data);
    end
  end

  assign dataA       = dataa_q;
  assign dataB       = datab_q;
  assign clk_en      = clk_en_q;
  assign fifo_level  = level_q;
  assign err_illegal = err_illegal_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_encoder
//   Directed scenarios plus a randomized run for instruction_encoder. A
//   negedge scoreboard tracks accepted commands as a queue of expected words
//   and checks issue order, held data, level, ready, spacing and error state.
// ---------------------------------------------------------------------------
module tb_instruction_encoder;

  localparam int FIFO_DEPTH = 4;
  localparam int ISSUE_GAP  = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode = 4'd0;
  logic [16:0] cmd_register = 17'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        new_instruction = 1'b0;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        clk_en;
  logic [4:0]  fifo_level;
  logic        err_illegal;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  instruction_encoder #(.FIFO_DEPTH(FIFO_DEPTH), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_register(cmd_register), .cmd_data(cmd_data),
    .new_instruction(new_instruction), .dataA(dataA), .dataB(dataB),
    .clk_en(clk_en), .fifo_level(fifo_level), .err_illegal(err_illegal),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Expected {dataA, dataB} from the opcode rules, using plain arithmetic.
  function automatic logic [63:0] model_word(input logic [3:0] op, input logic [16:0] r,
                                             input logic [31:0] d);
    int unsigned a;
    int unsigned b;
    if (op == 4'd0 || op == 4'd2) begin
      a = (32'(r) % 32'd32) * 32'd16 + 32'(op);
      b = d;
    end else if (op == 4'd1) begin
      a = 32'(r) * 32'd16 + 32'd1;
      b = d;
    end else begin
      a = 32'd3;
      b = 32'd0;
    end
    return {a, b};
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] w;
  int          written = 0;
  int          issued  = 0;
  int          ill_cnt = 0;
  bit          ill_pend = 1'b0;
  bit          rst_pend = 1'b0;
  bit          mon_en   = 1'b0;
  int          since    = 100;
  logic [31:0] last_a   = 32'd0;
  logic [31:0] last_b   = 32'd0;

  always @(negedge clk) begin
    if (rst_pend) begin
      exp_q.delete();
      written = 0; issued = 0; ill_cnt = 0; ill_pend = 1'b0;
      last_a = 32'd0; last_b = 32'd0; since = 100; mon_en = 1'b1;
    end
    if (mon_en) begin
      if (clk_en === 1'b1) begin
        issued++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL sb_unexpected_issue got dataA=%h dataB=%h with nothing queued", dataA, dataB);
        end else begin
          w = exp_q.pop_front(); last_a = w[63:32]; last_b = w[31:0];
        end
        total++;
        if (since < 1 + ISSUE_GAP) begin
          bad++; $display("FAIL sb_issue_spacing got %0d idle cycles need >= %0d", since, 1 + ISSUE_GAP);
        end
        since = 0;
      end else begin
        since++;
      end
      total++;
      if ({dataA, dataB} !== {last_a, last_b}) begin
        bad++; $display("FAIL sb_data got %h_%h expected %h_%h", dataA, dataB, last_a, last_b);
      end
      total++;
      if (fifo_level !== 5'(written - issued)) begin
        bad++; $display("FAIL sb_level got %0d expected %0d", fifo_level, written - issued);
      end
      total++;
      if (err_illegal !== ill_pend) begin
        bad++; $display("FAIL sb_err_illegal got %b expected %b", err_illegal, ill_pend);
      end
      total++;
      if (err_count !== 8'((ill_cnt > 255) ? 255 : ill_cnt)) begin
        bad++; $display("FAIL sb_err_count got %0d expected %0d", err_count, (ill_cnt > 255) ? 255 : ill_cnt);
      end
      total++;
      if (cmd_ready !== ((reset !== 1'b1) && (written - issued != FIFO_DEPTH))) begin
        bad++; $display("FAIL sb_ready got %b level_model=%0d reset=%b", cmd_ready, written - issued, reset);
      end
    end
    // Events that take effect at the coming rising edge.
    ill_pend = 1'b0;
    rst_pend = (reset === 1'b1);
    if (mon_en && !rst_pend && cmd_valid && (written - issued != FIFO_DEPTH)) begin
      if (cmd_opcode < 4'd4) begin
        exp_q.push_back(model_word(cmd_opcode, cmd_register, cmd_data));
        written++;
      end else begin
        ill_pend = 1'b1;
        ill_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [16:0] r, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_register = r; cmd_data = d;
  endtask

  task automatic idle_drain(input int n);
    cmd_valid = 1'b0; new_instruction = 1'b0;
    cyc(n);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL reset_clk_en got %b need 0", clk_en); end
    total++; if ({dataA, dataB} !== 64'd0) begin bad++; $display("FAIL reset_data got %h_%h need 0", dataA, dataB); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got %0d need 0", fifo_level); end
    total++; if (err_count !== 8'd0 || err_illegal !== 1'b0) begin bad++; $display("FAIL reset_err got %0d/%b need 0/0", err_count, err_illegal); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b need 0", cmd_ready); end
    reset = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got %b need 1", cmd_ready); end
    cyc(1);
  endtask

  task automatic test_latency;
    drive(4'd0, 17'd5, 32'h0064_0032);
    cyc(1);
    cmd_valid = 1'b0;
    total++; if (clk_en !== 1'b0 || fifo_level !== 5'd1) begin bad++; $display("FAIL latency_n1 got clk_en=%b level=%0d need 0/1", clk_en, fifo_level); end
    cyc(1);
    total++; if (clk_en !== 1'b1) begin bad++; $display("FAIL latency_n2 got clk_en=%b need 1", clk_en); end
    total++; if (dataA !== 32'h0000_0050 || dataB !== 32'h0064_0032) begin bad++; $display("FAIL op0_words got %h_%h need 00000050_00640032", dataA, dataB); end
    cyc(1);
    total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL single_pulse got clk_en=%b need 0", clk_en); end
    idle_drain(4);
  endtask

  task automatic test_op1_op3;
    logic [63:0] expw [2];
    int          n;
    expw[0] = {32'h001A_BCD1, 32'h0000_01FF};
    expw[1] = {32'h0000_0003, 32'h0000_0000};
    n = 0;
    drive(4'd1, 17'h1ABCD, 32'h0000_01FF);
    cyc(1);
    drive(4'd3, 17'h1FFFF, 32'hDEAD_BEEF);
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      cmd_valid = 1'b0;
      if (clk_en === 1'b1) begin
        if (n < 2) begin
          total++;
          if ({dataA, dataB} !== expw[n]) begin bad++; $display("FAIL op1_op3_word%0d got %h_%h need %h", n, dataA, dataB, expw[n]); end
        end
        n++;
      end
    end
    total++; if (n != 2) begin bad++; $display("FAIL op1_op3_count got %0d pulses need 2", n); end
  endtask

  task automatic test_full_stall;
    logic [63:0] expw [4];
    int          times [4];
    int          n;
    new_instruction = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(4'(k % 3), 17'(k * 7 + 3), 32'hA000_0000 + 32'(k));
      expw[k] = model_word(4'(k % 3), 17'(k * 7 + 3), 32'hA000_0000 + 32'(k));
      cyc(1);
    end
    cmd_valid = 1'b0;
    total++; if (fifo_level !== 5'd4 || cmd_ready !== 1'b0) begin bad++; $display("FAIL full_state got level=%0d ready=%b need 4/0", fifo_level, cmd_ready); end
    drive(4'd0, 17'd1, 32'h5555_5555);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      total++; if (clk_en !== 1'b0 || fifo_level !== 5'd4) begin bad++; $display("FAIL stall_hold got clk_en=%b level=%0d need 0/4", clk_en, fifo_level); end
    end
    cmd_valid = 1'b0;
    new_instruction = 1'b0;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (clk_en === 1'b1) begin
        if (n < 4) begin
          times[n] = i;
          total++;
          if ({dataA, dataB} !== expw[n]) begin bad++; $display("FAIL stall_order%0d got %h_%h need %h", n, dataA, dataB, expw[n]); end
        end
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL stall_pulses got %0d need 4", n); end
    if (n == 4) begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (times[k] != 1 + k * (2 + ISSUE_GAP)) begin bad++; $display("FAIL stall_timing%0d got cycle %0d need %0d", k, times[k], 1 + k * (2 + ISSUE_GAP)); end
      end
    end
    idle_drain(4);
  endtask

  task automatic test_illegal;
    drive(4'd9, 17'd3, 32'h1234_5678);
    cyc(1);
    cmd_valid = 1'b0;
    total++; if (err_illegal !== 1'b1 || err_count !== 8'd1) begin bad++; $display("FAIL illegal_first got pulse=%b count=%0d need 1/1", err_illegal, err_count); end
    cyc(1);
    total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse_len got %b need 0", err_illegal); end
    for (int k = 0; k < 4; k++) begin
      total++; if (clk_en !== 1'b0 || fifo_level !== 5'd0) begin bad++; $display("FAIL illegal_no_issue got clk_en=%b level=%0d", clk_en, fifo_level); end
      cyc(1);
    end
    for (int k = 0; k < 256; k++) begin
      drive(4'($urandom_range(4, 15)), 17'($urandom), $urandom);
      cyc(1);
    end
    cmd_valid = 1'b0;
    cyc(1);
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL illegal_saturate got %0d need 255", err_count); end
  endtask

  task automatic test_reset_mid;
    int first_at;
    first_at = -1;
    for (int k = 0; k < 3; k++) begin
      drive(4'd2, 17'(k + 10), 32'hC0DE_0000 + 32'(k));
      cyc(1);
      if (clk_en === 1'b1 && first_at < 0) first_at = k;
    end
    cmd_valid = 1'b0;
    total++; if (first_at != 1) begin bad++; $display("FAIL mid_first_issue got step %0d need 1", first_at); end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    total++; if (clk_en !== 1'b0 || fifo_level !== 5'd0 || err_count !== 8'd0) begin bad++; $display("FAIL mid_reset got clk_en=%b level=%0d errs=%0d need 0/0/0", clk_en, fifo_level, err_count); end
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      total++; if (clk_en !== 1'b0 || fifo_level !== 5'd0) begin bad++; $display("FAIL mid_no_issue got clk_en=%b level=%0d", clk_en, fifo_level); end
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    new_instruction = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(4'($urandom_range(0, 3)), 17'($urandom), $urandom);
      cyc(1);
    end
    cmd_valid = 1'b0;
    new_instruction = 1'b0;
    for (int j = 0; j < 8; j++) begin
      drive(4'($urandom_range(0, 3)), 17'($urandom), $urandom);
      for (int s = 0; s < 3; s++) begin
        cyc(1);
        cmd_valid = 1'b0;
        if (clk_en === 1'b1) pulses++;
        total++; if (fifo_level !== 5'd2) begin bad++; $display("FAIL b2b_level round %0d got %0d need 2", j, fifo_level); end
      end
    end
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (clk_en === 1'b1) pulses++;
    end
    total++; if (pulses != 10) begin bad++; $display("FAIL b2b_count got %0d pulses need 10", pulses); end
  endtask

  task automatic test_random;
    int r;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_opcode = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
      cmd_register = 17'($urandom);
      cmd_data = $urandom;
      new_instruction = $urandom_range(0, 3) == 0;
      cyc(1);
    end
    idle_drain(40);
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL random_drain_level got %0d need 0", fifo_level); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL random_drain_queue got %0d outstanding need 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_op1_op3();
    test_full_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
